i2c_req_arbiter: RTL and testbench

//  Shares one single-byte I2C master between NUM_REQ client requesters.

---
 rtl/i2c_req_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_i2c_req_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one single-byte I2C master between NUM_REQ clients,
// sequencing the enable/busy handshake and recovering a hung master with a reset pulse.
//
//   state     | meaning
//   S_IDLE    | no transaction; pick next requester round-robin
//   S_GRANT   | grant and request fields latched; raise m_enable next
//   S_WAIT_HI | m_enable high, waiting for synchronised busy to rise
//   S_WAIT_LO | transfer running, waiting for synchronised busy to fall
//   S_RECOVER | m_rst held high for RST_CYCLES, then err pulse
//   S_DONE    | done or err pulse cycle; release grant, move pointer
module i2c_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int START_TO   = 1024,
  parameter int XFER_TO    = 16384,
  parameter int RST_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]     req_rw,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     err,
  output logic [7:0]             rdata,
  output logic                   m_enable,
  output logic [6:0]             m_addr,
  output logic                   m_rw,
  output logic [7:0]             m_data_in,
  input  logic [7:0]             m_data_out,
  input  logic                   m_busy,
  output logic                   m_rst
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(XFER_TO) + 1;
  localparam logic [TW-1:0] START_LAST = TW'(START_TO - 1);
  localparam logic [TW-1:0] XFER_LAST  = TW'(XFER_TO - 1);
  localparam logic [TW-1:0] RST_LAST   = TW'(RST_CYCLES - 1);
  localparam logic [PW-1:0] PTR_INIT   = PW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT_HI,
    S_WAIT_LO,
    S_RECOVER,
    S_DONE
  } state_t;

  state_t               state;
  logic [PW-1:0]        ptr;
  logic [PW-1:0]        win;
  logic [TW-1:0]        timer;
  logic [TW-1:0]        timer_inc;
  logic                 busy_meta;
  logic                 busy_s;
  logic [PW-1:0]        pick;
  logic [NUM_REQ-1:0]   pick_hot;
  logic [6:0]           sel_addr;
  logic                 sel_rw;
  logic [7:0]           sel_wdata;

  // m_busy comes from the master's derived clock domain
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
    end else begin
      busy_meta <= m_busy;
      busy_s    <= busy_meta;
    end
  end

  // Scan downward so the nearest requester after ptr is the last assignment
  always_comb begin
    int idx;
    idx  = 0;
    pick = ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req[PW'(idx)]) pick = PW'(idx);
    end
  end

  always_comb begin
    pick_hot  = '0;
    sel_addr  = '0;
    sel_rw    = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == PW'(i)) begin
        pick_hot[i] = 1'b1;
        sel_addr    = req_addr[7*i +: 7];
        sel_rw      = req_rw[i];
        sel_wdata   = req_wdata[8*i +: 8];
      end
    end
  end

  assign timer_inc = (&timer) ? timer : timer + TW'(1);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= S_IDLE;
      ptr       <= PTR_INIT;
      win       <= '0;
      timer     <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      rdata     <= '0;
      m_enable  <= 1'b0;
      m_addr    <= '0;
      m_rw      <= 1'b0;
      m_data_in <= '0;
      m_rst     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            win       <= pick;
            gnt       <= pick_hot;
            m_addr    <= sel_addr;
            m_rw      <= sel_rw;
            m_data_in <= sel_wdata;
            state     <= S_GRANT;
          end
        end
        S_GRANT: begin
          m_enable <= 1'b1;
          timer    <= '0;
          state    <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (busy_s) begin
            m_enable <= 1'b0;
            timer    <= '0;
            state    <= S_WAIT_LO;
          end else if (timer == START_LAST) begin
            m_enable <= 1'b0;
            m_rst    <= 1'b1;
            timer    <= '0;
            state    <= S_RECOVER;
          end else begin
            timer <= timer_inc;
          end
        end
        S_WAIT_LO: begin
          if (!busy_s) begin
            if (m_rw) rdata <= m_data_out;
            done  <= gnt;
            state <= S_DONE;
          end else if (timer == XFER_LAST) begin
            m_rst <= 1'b1;
            timer <= '0;
            state <= S_RECOVER;
          end else begin
            timer <= timer_inc;
          end
        end
        S_RECOVER: begin
          if (timer == RST_LAST) begin
            m_rst <= 1'b0;
            err   <= gnt;
            state <= S_DONE;
          end else begin
            timer <= timer_inc;
          end
        end
        S_DONE: begin
          done  <= '0;
          err   <= '0;
          gnt   <= '0;
          ptr   <= win;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomised and directed bench for i2c_req_arbiter: a transaction-timeline model predicts
// every output each cycle, and directed scenarios pin timing and ordering with literals.
module tb_i2c_req_arbiter;

  localparam int N          = 4;
  localparam int START_TO   = 1024;
  localparam int XFER_TO    = 16384;
  localparam int RST_CYCLES = 16;

  logic           clk = 1'b0;
  logic           arst = 1'b1;
  logic [N-1:0]   req;
  logic [7*N-1:0] req_addr;
  logic [N-1:0]   req_rw;
  logic [8*N-1:0] req_wdata;
  logic [N-1:0]   gnt, done, err;
  logic [7:0]     rdata;
  logic           m_enable;
  logic [6:0]     m_addr;
  logic           m_rw;
  logic [7:0]     m_data_in;
  logic [7:0]     m_data_out;
  logic           m_busy;
  logic           m_rst;

  i2c_req_arbiter #(
    .NUM_REQ(N), .START_TO(START_TO), .XFER_TO(XFER_TO), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk), .arst(arst), .req(req), .req_addr(req_addr), .req_rw(req_rw),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .m_enable(m_enable), .m_addr(m_addr), .m_rw(m_rw), .m_data_in(m_data_in),
    .m_data_out(m_data_out), .m_busy(m_busy), .m_rst(m_rst)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- reference model: one transaction as a timeline ----------------
  logic [N-1:0] e_gnt, e_done, e_err;
  logic [7:0]   e_rdata, e_wd;
  logic [6:0]   e_addr;
  logic         e_en, e_rw, e_rst;
  int           ptr_m;
  logic         bh0, bh1, bs_use;

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 1; k <= N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    e_gnt = '0; e_done = '0; e_err = '0; e_rdata = '0; e_wd = '0; e_addr = '0;
    e_en = 1'b0; e_rw = 1'b0; e_rst = 1'b0; ptr_m = N - 1;
    bh0 = 1'b0; bh1 = 1'b0; bs_use = 1'b0;
  endtask

  // Busy as the arbiter sees it: m_busy as it was two clock edges earlier
  task automatic mtick(output bit r);
    @(posedge clk or posedge arst);
    r = arst;
    bs_use = bh1;
    bh1 = bh0;
    bh0 = m_busy;
  endtask

  task automatic model_txn(output bit r);
    int  w;
    bit  started, finished;
    started = 0;
    finished = 0;
    mtick(r); if (r) return;
    if (req == '0) return;
    w      = rr_pick(req, ptr_m);
    e_gnt  = N'(1) << w;
    e_addr = req_addr[7*w +: 7];
    e_rw   = req_rw[w];
    e_wd   = req_wdata[8*w +: 8];
    mtick(r); if (r) return;
    e_en = 1'b1;
    for (int j = 1; j <= START_TO; j++) begin
      mtick(r); if (r) return;
      if (bs_use) begin started = 1; break; end
    end
    e_en = 1'b0;
    if (started) begin
      for (int j = 1; j <= XFER_TO; j++) begin
        mtick(r); if (r) return;
        if (!bs_use) begin finished = 1; break; end
      end
    end
    if (finished) begin
      if (e_rw) e_rdata = m_data_out;
      e_done = e_gnt;
    end else begin
      e_rst = 1'b1;
      for (int j = 0; j < RST_CYCLES; j++) begin
        mtick(r); if (r) return;
      end
      e_rst = 1'b0;
      e_err = e_gnt;
    end
    mtick(r); if (r) return;
    e_done = '0; e_err = '0; e_gnt = '0; ptr_m = w;
  endtask

  initial begin : model
    bit r;
    forever begin
      model_reset();
      wait (arst == 1'b0);
      r = 0;
      while (!r) model_txn(r);
    end
  end

  // ---------------- compare process and event log ----------------
  int   cyc = 0;
  int   gnt_q[$];
  int   en_rise = 0, en_fall = 0, rst_rise = 0, rst_fall = 0;
  int   done_cnt = 0, err_cnt = 0;
  logic prev_en = 1'b0, prev_rst = 1'b0;
  logic [N-1:0] prev_gnt = '0;

  always @(negedge clk) begin
    cyc++;
    check("gnt", gnt, e_gnt);
    check("done", done, e_done);
    check("err", err, e_err);
    check("rdata", rdata, e_rdata);
    check("m_enable", m_enable, e_en);
    check("m_addr", m_addr, e_addr);
    check("m_rw", m_rw, e_rw);
    check("m_data_in", m_data_in, e_wd);
    check("m_rst", m_rst, e_rst);
    if (gnt != '0 && prev_gnt == '0)
      for (int i = 0; i < N; i++) if (gnt[i]) gnt_q.push_back(i);
    if (m_enable && !prev_en) en_rise = cyc;
    if (!m_enable && prev_en) en_fall = cyc;
    if (m_rst && !prev_rst) rst_rise = cyc;
    if (!m_rst && prev_rst) rst_fall = cyc;
    if (done != '0) done_cnt++;
    if (err != '0) err_cnt++;
    prev_gnt = gnt;
    prev_en  = m_enable;
    prev_rst = m_rst;
  end

  // ---------------- I2C master model ----------------
  int         force_mode = 0;  // -1 random, 0 normal, 1 busy never rises, 2 busy stuck high
  int         force_dly = 2, force_len = 4;
  logic [7:0] force_data = 8'h00;

  initial begin : master
    int mode, dly, len;
    m_busy = 1'b0;
    m_data_out = 8'h00;
    forever begin
      tick();
      if (arst) begin
        m_busy = 1'b0;
      end else if (m_enable) begin
        if (force_mode >= 0) begin
          mode = force_mode; dly = force_dly; len = force_len; m_data_out = force_data;
        end else begin
          mode = ($urandom_range(0, 15) == 0) ? 1 : 0;
          dly  = $urandom_range(0, 12);
          len  = $urandom_range(1, 30);
          m_data_out = 8'($urandom);
        end
        if (mode == 0) begin
          for (int i = 0; i < dly && !arst; i++) tick();
          m_busy = !arst;
          for (int i = 0; i < len && !arst; i++) tick();
          m_busy = 1'b0;
          for (int i = 0; i < 20 && m_enable && !arst; i++) tick();
        end else begin
          if (mode == 2) m_busy = 1'b1;
          for (int i = 0; i < XFER_TO + START_TO + 100 && !m_rst && !arst; i++) tick();
          m_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_pulse(input int i, input int bound, output bit gd, output bit ge);
    gd = 0;
    ge = 0;
    for (int c = 0; c < bound && !gd && !ge; c++) begin
      tick();
      gd = done[i];
      ge = err[i];
    end
  endtask

  task automatic wait_any_done(input int bound, output bit gd);
    gd = 0;
    for (int c = 0; c < bound && !gd; c++) begin
      tick();
      gd = |done;
    end
  endtask

  function automatic int gq(input int k);
    return (k < gnt_q.size()) ? gnt_q[k] : -1;
  endfunction

  initial begin : stim
    bit gd, ge;
    int base, dbase, n_txn;
    int exp_order[6];
    req = '0; req_addr = '0; req_rw = '0; req_wdata = '0;
    arst = 1'b1;
    repeat (4) tick();
    check("rst_gnt", gnt, 0);
    check("rst_m_enable", m_enable, 0);
    check("rst_m_rst", m_rst, 0);
    arst = 1'b0;
    tick();

    // Arbitration order from reset, then 1001 after client 3 was last served
    base = gnt_q.size();
    req_addr = {7'h13, 7'h12, 7'h11, 7'h10};
    req_wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req_rw = '0;
    force_mode = 0; force_dly = 2; force_len = 4; force_data = 8'h77;
    req = 4'b1111;
    for (int t = 0; t < 4; t++) begin
      wait_any_done(200, gd);
      check("t3_done", gd, 1);
    end
    req = 4'b1001;
    for (int t = 0; t < 2; t++) begin
      wait_any_done(200, gd);
      check("t3b_done", gd, 1);
    end
    req = '0;
    repeat (3) tick();
    exp_order = '{0, 1, 2, 3, 0, 3};
    check("t3_grants", gnt_q.size() - base, 6);
    for (int k = 0; k < 6; k++) check("t3_order", gq(base + k), exp_order[k]);

    // Long write
    req_addr[6:0] = 7'h50; req_rw[0] = 1'b0; req_wdata[7:0] = 8'hA5;
    force_mode = 0; force_dly = 3; force_len = 5000;
    dbase = done_cnt;
    req = 4'b0001;
    wait_pulse(0, 6000, gd, ge);
    check("t1_done", gd, 1);
    check("t1_m_addr", m_addr, 7'h50);
    check("t1_model_addr", e_addr, 7'h50);
    check("t1_m_data_in", m_data_in, 8'hA5);
    check("t1_rdata", rdata, 8'h00);
    req = '0;
    repeat (3) tick();
    check("t1_done_once", done_cnt - dbase, 1);

    // Read
    req_addr[13:7] = 7'h21; req_rw[1] = 1'b1;
    force_len = 6; force_data = 8'h3C;
    req = 4'b0010;
    wait_pulse(1, 300, gd, ge);
    check("t2_done", gd, 1);
    check("t2_rdata", rdata, 8'h3C);
    check("t2_model_rdata", e_rdata, 8'h3C);
    req = '0;
    repeat (3) tick();

    // Busy never rises
    force_mode = 1;
    req = 4'b0001;
    wait_pulse(0, START_TO + RST_CYCLES + 100, gd, ge);
    check("t4_err", ge, 1);
    req = '0;
    tick();
    check("t4_rst_start", rst_rise - en_rise, START_TO);
    check("t4_rst_width", rst_fall - rst_rise, RST_CYCLES);
    check("t4_rdata_kept", rdata, 8'h3C);

    // Busy stuck high, then a normal transaction
    force_mode = 2;
    req = 4'b0100;
    wait_pulse(2, XFER_TO + START_TO + 200, gd, ge);
    check("t5_err", ge, 1);
    req = '0;
    tick();
    check("t5_xfer_to", rst_rise - en_fall, XFER_TO);
    force_mode = 0; force_len = 5; force_data = 8'h5A;
    req_rw[3] = 1'b1;
    req = 4'b1000;
    wait_pulse(3, 300, gd, ge);
    check("t5_next_done", gd, 1);
    check("t5_next_rdata", rdata, 8'h5A);
    req = '0;
    repeat (3) tick();

    // Reset in the middle of a transfer
    force_dly = 1; force_len = 300;
    req = 4'b0010;
    gd = 0;
    for (int c = 0; c < 50 && !gd; c++) begin
      tick();
      gd = gnt[1];
    end
    check("t6_granted", gd, 1);
    repeat (20) tick();
    arst = 1'b1;
    #1;
    check("t6_rst_gnt", gnt, 0);
    check("t6_rst_m_addr", m_addr, 0);
    check("t6_rst_rdata", rdata, 0);
    check("t6_rst_m_enable", m_enable, 0);
    req = 4'b0011;
    force_len = 5;
    repeat (3) tick();
    base = gnt_q.size();
    arst = 1'b0;
    wait_pulse(0, 300, gd, ge);
    check("t6_done0", gd, 1);
    req[0] = 1'b0;
    wait_pulse(1, 300, gd, ge);
    check("t6_done1", gd, 1);
    req = '0;
    check("t6_first_grant", gq(base), 0);
    repeat (3) tick();

    // Random traffic
    force_mode = -1;
    n_txn = 0;
    for (int c = 0; c < 25000 && n_txn < 100; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (done[i] || err[i]) begin
          req[i] = 1'b0;
          n_txn++;
        end else if (!req[i]) begin
          req_addr[7*i +: 7]  = 7'($urandom);
          req_rw[i]           = 1'($urandom);
          req_wdata[8*i +: 8] = 8'($urandom);
          if ($urandom_range(0, 7) == 0) req[i] = 1'b1;
        end else if (gnt[i] && $urandom_range(0, 30) == 0) begin
          req_addr[7*i +: 7]  = 7'($urandom);
          req_wdata[8*i +: 8] = 8'($urandom);
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end
      end
    end
    req = '0;
    gd = 0;
    for (int c = 0; c < START_TO + RST_CYCLES + 200 && !gd; c++) begin
      tick();
      gd = (gnt == '0);
    end
    check("final_idle", gd, 1);
    repeat (5) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
